gyro_bias_calibrate: RTL
========================

Name: gyro_bias_calibrate

Overview:
Sits directly upstream of the gyro integrator. Takes raw signed 16-bit gyro rate samples from the IMU reader, each qualified by a valid strobe. At startup or on request it discards settling samples, then averages a fixed window to estimate the per-axis zero-rate bias. In normal operation it outputs bias-corrected, deadbanded, saturated rates, held between samples so the integrator can accumulate them every cycle.

Parameters:
CAL_SAMPLES_LOG2, 8, log2 of the number of samples averaged for bias (256 by default).
SETTLE_SAMPLES, 16, number of valid samples discarded before averaging; 0 is legal and means no settling.
DEADBAND, 4, corrected magnitude (LSB) at or below which the output is forced to 0.

Ports:
clk_100mhz  in  1  system clock
rst_in  in  1  asynchronous, active-low reset
sample_valid_in  in  1  one-cycle strobe: gx_in/gy_in/gz_in hold a new sample
gx_in  in  16  signed raw rate, x axis
gy_in  in  16  signed raw rate, y axis
gz_in  in  16  signed raw rate, z axis
recal_in  in  1  one-cycle pulse: restart calibration
gx_out  out  16  signed corrected rate, x axis; held between samples
gy_out  out  16  signed corrected rate, y axis; held between samples
gz_out  out  16  signed corrected rate, z axis; held between samples
sample_valid_out  out  1  one-cycle strobe: outputs were just updated
calibrated_out  out  1  high while in RUN
bias_x_out, bias_y_out, bias_z_out  out  16 each  signed current bias estimate

Behaviour:
- Reset (rst_in low, asynchronous): state=SETTLE; counters, accumulators, biases and all outputs are 0. Reset mid-calibration discards all partial sums.
- Only cycles with sample_valid_in=1 advance the state machine. Idle cycles change nothing except sample_valid_out, which returns to 0.
- SETTLE: count valid samples and discard them. After SETTLE_SAMPLES samples, go to ACCUM. With SETTLE_SAMPLES=0, go straight to ACCUM after reset or recal.
- ACCUM: per-axis accumulator, signed, 16+CAL_SAMPLES_LOG2 bits, adds the sign-extended input on each valid sample. On the 2^CAL_SAMPLES_LOG2-th sample, the sum including that sample is computed. bias = sum >>> CAL_SAMPLES_LOG2 (arithmetic, floor toward -inf). Latch the bias, clear the accumulators, go to RUN, and set calibrated_out on the next edge.
- SETTLE and ACCUM: gx/gy/gz_out are held at 0 and sample_valid_out stays 0, so the integrator sees zero rate.
- RUN: each valid sample computes d = in - bias in 17-bit signed arithmetic.
  - If |d| <= DEADBAND, the result is 0.
  - Otherwise the result is d saturated to [-32768, 32767].
  - Outputs are registered, with latency 1: sample at edge N, outputs and sample_valid_out=1 after edge N+1, sample_valid_out=0 after N+2 unless another sample arrives.
  - Back-to-back valid samples are supported at full rate.
- recal_in=1 in any state: on the next edge go to SETTLE, clear counters and accumulators, zero the outputs, and drop calibrated_out and sample_valid_out.
  - Biases are held (not cleared) until the new calibration completes.
  - recal_in and sample_valid_in in the same cycle: recal wins and the sample is discarded.
- The bias outputs always reflect the bias registers.

Optional Feature:
GYRO_BIAS_TRACK_EN.
- Defined: in RUN, each valid sample with 0 < |d| <= DEADBAND adds sign(d) (±1 LSB) to that axis's bias, applied on the same edge as the output update. That sample's output is still 0. d=0 makes no change. Bias saturates at ±32767/-32768.
- Undefined: bias is frozen between calibrations.
- Tests below assume the macro is undefined unless stated.

Test Plan:
- Params L=2, SETTLE=1, DEADBAND=4. Send 1 sample (gx=999), then gx=10,11,12,13 → bias_x_out=11 and calibrated_out=1 after the 5th sample; outputs 0 and sample_valid_out never high before that.
- Negative floor: gy samples -5,-6,-5,-6 → sum -22, bias_y_out=-6. Then gy_in=-106 → gy_out=-100 one cycle after valid, with a one-cycle sample_valid_out pulse.
- Saturation, bias_x=11, bias_y=-6: gx_in=-32768 → gx_out=-32768; gy_in=32767 → gy_out=32767.
- Deadband, bias_z=0:
  - gz_in=3 → gz_out=0
  - gz_in=-4 → gz_out=0
  - gz_in=5 → gz_out=5
  - outputs held unchanged across 10 idle cycles.
- Recal in RUN, asserted together with a valid sample → that sample is ignored; outputs go to 0 and calibrated_out to 0 next cycle; old biases are retained until 5 new samples yield a new bias.
- Reset asserted mid-ACCUM after 2 samples → everything zero immediately (asynchronously); a full fresh sequence is required.
- With GYRO_BIAS_TRACK_EN defined, bias_x=11: gx_in=13 → bias_x_out=12, gx_out=0; then gx_in=12 → bias unchanged, gx_out=0.

Source files
------------

// File: rtl/gyro_bias_calibrate.sv
// Gyro zero-rate bias calibration: settle, average a window, then output bias-corrected,
// deadbanded, saturated rates. Define GYRO_BIAS_TRACK_EN for slow in-deadband bias tracking.
module gyro_bias_calibrate #(
  parameter int CAL_SAMPLES_LOG2 = 8,
  parameter int SETTLE_SAMPLES   = 16,
  parameter int DEADBAND         = 4
) (
  input  logic        clk_100mhz,
  input  logic        rst_in,
  input  logic        sample_valid_in,
  input  logic [15:0] gx_in,
  input  logic [15:0] gy_in,
  input  logic [15:0] gz_in,
  input  logic        recal_in,
  output logic [15:0] gx_out,
  output logic [15:0] gy_out,
  output logic [15:0] gz_out,
  output logic        sample_valid_out,
  output logic        calibrated_out,
  output logic [15:0] bias_x_out,
  output logic [15:0] bias_y_out,
  output logic [15:0] bias_z_out
);

  localparam int AW = 16 + CAL_SAMPLES_LOG2;
  localparam int SW = (SETTLE_SAMPLES > 1) ? $clog2(SETTLE_SAMPLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE_SAMPLES > 0) ? SETTLE_SAMPLES - 1 : 0);

  localparam logic [1:0] ST_SETTLE = 2'd0;
  localparam logic [1:0] ST_ACCUM  = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;
  // With no settling, reset and recal land directly in ACCUM.
  localparam logic [1:0] ST_START  = (SETTLE_SAMPLES == 0) ? ST_ACCUM : ST_SETTLE;

  logic [1:0]                  state;
  logic [SW-1:0]               settle_cnt;
  logic [CAL_SAMPLES_LOG2-1:0] acc_cnt;
  logic                        valid_out;

  logic signed [AW-1:0] acc      [3];
  logic signed [15:0]   bias     [3];
  logic signed [15:0]   rate_out [3];

  logic signed [15:0]   raw      [3];
  logic signed [17:0]   diff     [3];
  logic [17:0]          mag      [3];
  logic                 in_band  [3];
  logic signed [15:0]   corr     [3];
  logic signed [AW-1:0] sum_next [3];
`ifdef GYRO_BIAS_TRACK_EN
  logic signed [15:0]   tracked  [3];
`endif

  always_comb begin
    raw[0] = gx_in;
    raw[1] = gy_in;
    raw[2] = gz_in;
    for (int unsigned i = 0; i < 3; i++) begin
      diff[i]     = $signed({{2{raw[i][15]}}, raw[i]}) - $signed({{2{bias[i][15]}}, bias[i]});
      mag[i]      = diff[i][17] ? 18'(-diff[i]) : 18'(diff[i]);
      in_band[i]  = (mag[i] <= 18'(DEADBAND));
      sum_next[i] = acc[i] + $signed({{CAL_SAMPLES_LOG2{raw[i][15]}}, raw[i]});
      if (in_band[i])
        corr[i] = '0;
      else if (diff[i] > 18'sd32767)
        corr[i] = 16'sh7fff;
      else if (diff[i] < -18'sd32768)
        corr[i] = 16'sh8000;
      else
        corr[i] = diff[i][15:0];
`ifdef GYRO_BIAS_TRACK_EN
      tracked[i] = bias[i];
      if (in_band[i] && diff[i] > 18'sd0 && bias[i] != 16'sh7fff)
        tracked[i] = bias[i] + 16'sd1;
      else if (in_band[i] && diff[i] < 18'sd0 && bias[i] != 16'sh8000)
        tracked[i] = bias[i] - 16'sd1;
`endif
    end
  end

  always_ff @(posedge clk_100mhz or negedge rst_in) begin
    if (!rst_in) begin
      state      <= ST_START;
      settle_cnt <= '0;
      acc_cnt    <= '0;
      valid_out  <= 1'b0;
      for (int unsigned i = 0; i < 3; i++) begin
        acc[i]      <= '0;
        bias[i]     <= '0;
        rate_out[i] <= '0;
      end
    end else begin
      valid_out <= 1'b0;
      if (recal_in) begin
        state      <= ST_START;
        settle_cnt <= '0;
        acc_cnt    <= '0;
        for (int unsigned i = 0; i < 3; i++) begin
          acc[i]      <= '0;
          rate_out[i] <= '0;
        end
      end else if (sample_valid_in) begin
        case (state)
          ST_SETTLE: begin
            if (settle_cnt == SETTLE_LAST) begin
              settle_cnt <= '0;
              state      <= ST_ACCUM;
            end else begin
              settle_cnt <= settle_cnt + SW'(1);
            end
          end
          ST_ACCUM: begin
            acc_cnt <= acc_cnt + CAL_SAMPLES_LOG2'(1);
            // Floor average is just the window sum with the low LOG2 bits dropped.
            for (int unsigned i = 0; i < 3; i++) begin
              if (&acc_cnt) begin
                bias[i] <= sum_next[i][CAL_SAMPLES_LOG2 +: 16];
                acc[i]  <= '0;
              end else begin
                acc[i]  <= sum_next[i];
              end
            end
            if (&acc_cnt)
              state <= ST_RUN;
          end
          ST_RUN: begin
            valid_out <= 1'b1;
            for (int unsigned i = 0; i < 3; i++) begin
              rate_out[i] <= corr[i];
`ifdef GYRO_BIAS_TRACK_EN
              bias[i]     <= tracked[i];
`endif
            end
          end
          default: state <= ST_START;
        endcase
      end
    end
  end

  assign gx_out           = rate_out[0];
  assign gy_out           = rate_out[1];
  assign gz_out           = rate_out[2];
  assign bias_x_out       = bias[0];
  assign bias_y_out       = bias[1];
  assign bias_z_out       = bias[2];
  assign sample_valid_out = valid_out;
  assign calibrated_out   = (state == ST_RUN);

endmodule
